// File: rtl/frame_sync_tx.sv
// Raster sync generator: programmable hsync/vsync strobes with a 12-bit sample
// stream gated onto the DAC output during the active window.
module frame_sync_tx #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  h_total_i,
    input  logic [CNT_W-1:0]  h_sync_len_i,
    input  logic [CNT_W-1:0]  h_act_start_i,
    input  logic [CNT_W-1:0]  h_act_len_i,
    input  logic [CNT_W-1:0]  v_total_i,
    input  logic [CNT_W-1:0]  v_sync_len_i,
    input  logic [CNT_W-1:0]  v_act_start_i,
    input  logic [CNT_W-1:0]  v_act_len_i,
    input  logic [DATA_W-1:0] sample_data_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    output logic [DATA_W-1:0] dac_data_o,
    output logic              dac_valid_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              frame_done_o,
    output logic              underflow_o,
    output logic [15:0]       underflow_cnt_o,
    output logic              cfg_err_o
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_t state_reg, state_next;
    logic   load_cfg;

    logic [CNT_W-1:0] h_total_reg, h_sync_len_reg, h_act_start_reg, h_act_len_reg;
    logic [CNT_W-1:0] v_total_reg, v_sync_len_reg, v_act_start_reg, v_act_len_reg;
    logic [CNT_W-1:0] h_cnt_reg, v_cnt_reg;
    logic             rearm_block_reg;

    logic             run, h_last, v_last, frame_wrap;
    logic             hs, vs, h_in, v_in, act, cfg_bad;
    logic [CNT_W:0]   h_act_end, v_act_end;

    assign run        = (state_reg == RUN);
    assign h_last     = (h_cnt_reg == (h_total_reg - ONE));
    assign v_last     = (v_cnt_reg == (v_total_reg - ONE));
    assign frame_wrap = h_last && v_last;

    assign h_act_end  = {1'b0, h_act_start_reg} + {1'b0, h_act_len_reg};
    assign v_act_end  = {1'b0, v_act_start_reg} + {1'b0, v_act_len_reg};
    assign hs         = (h_cnt_reg < h_sync_len_reg);
    assign vs         = (v_cnt_reg < v_sync_len_reg);
    assign h_in       = (h_cnt_reg >= h_act_start_reg) && ({1'b0, h_cnt_reg} < h_act_end);
    assign v_in       = (v_cnt_reg >= v_act_start_reg) && ({1'b0, v_cnt_reg} < v_act_end);
    assign act        = h_in && v_in;

    assign sample_ready_o = run && act;

    // Checked on the raw inputs during ARM, i.e. exactly the values being latched.
    assign cfg_bad = (h_total_i < TWO) || (v_total_i == '0)
                  || (h_sync_len_i >= h_total_i) || (v_sync_len_i >= v_total_i)
                  || (h_act_len_i == '0) || (v_act_len_i == '0)
                  || (({1'b0, h_act_start_i} + {1'b0, h_act_len_i}) > {1'b0, h_total_i})
                  || (({1'b0, v_act_start_i} + {1'b0, v_act_len_i}) > {1'b0, v_total_i});

    always_comb begin
        state_next = state_reg;
        load_cfg   = 1'b0;
        case (state_reg)
            IDLE:  if (enable_i && !rearm_block_reg) state_next = ARM;
            ARM: begin
                load_cfg   = 1'b1;
                state_next = cfg_bad ? IDLE : RUN;
            end
            RUN: begin
                if (frame_wrap) begin
                    if (enable_i) load_cfg   = 1'b1;
                    else          state_next = DRAIN;
                end
            end
            DRAIN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            rearm_block_reg <= 1'b0;
            cfg_err_o       <= 1'b0;
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            h_total_reg     <= '0;
            h_sync_len_reg  <= '0;
            h_act_start_reg <= '0;
            h_act_len_reg   <= '0;
            v_total_reg     <= '0;
            v_sync_len_reg  <= '0;
            v_act_start_reg <= '0;
            v_act_len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            // A rejected config blocks re-arming until enable has been seen low.
            if (state_reg == ARM && cfg_bad) rearm_block_reg <= 1'b1;
            else if (!enable_i)              rearm_block_reg <= 1'b0;
            if (state_reg == ARM) cfg_err_o <= cfg_bad;
            if (load_cfg) begin
                h_total_reg     <= h_total_i;
                h_sync_len_reg  <= h_sync_len_i;
                h_act_start_reg <= h_act_start_i;
                h_act_len_reg   <= h_act_len_i;
                v_total_reg     <= v_total_i;
                v_sync_len_reg  <= v_sync_len_i;
                v_act_start_reg <= v_act_start_i;
                v_act_len_reg   <= v_act_len_i;
            end
            if (run) begin
                if (h_last) begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= v_last ? '0 : v_cnt_reg + ONE;
                end else begin
                    h_cnt_reg <= h_cnt_reg + ONE;
                end
            end else begin
                h_cnt_reg <= '0;
                v_cnt_reg <= '0;
            end
        end
    end

    // Output register: every strobe and sample is one clock behind its counter position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_o         <= 1'b0;
            vsync_o         <= 1'b0;
            dac_valid_o     <= 1'b0;
            dac_data_o      <= '0;
            frame_done_o    <= 1'b0;
            underflow_o     <= 1'b0;
            underflow_cnt_o <= '0;
        end else begin
            hsync_o      <= run && hs;
            vsync_o      <= run && vs;
            dac_valid_o  <= run && act;
            dac_data_o   <= (run && act && sample_valid_i) ? sample_data_i : '0;
            frame_done_o <= run && frame_wrap;
            underflow_o  <= run && act && !sample_valid_i;
            if (state_reg == ARM)
                underflow_cnt_o <= '0;
            else if (run && act && !sample_valid_i && underflow_cnt_o != 16'hFFFF)
                underflow_cnt_o <= underflow_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_frame_sync_tx.sv
// Randomized bench for frame_sync_tx: a frame-index reference model predicts
// every registered output; directed phases cover the documented scenarios.
module tb_frame_sync_tx;
    localparam int DW = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable_i;
    logic [CW-1:0] h_total_i, h_sync_len_i, h_act_start_i, h_act_len_i;
    logic [CW-1:0] v_total_i, v_sync_len_i, v_act_start_i, v_act_len_i;
    logic [DW-1:0] sample_data_i;
    logic          sample_valid_i;
    logic          sample_ready_o;
    logic [DW-1:0] dac_data_o;
    logic          dac_valid_o, hsync_o, vsync_o, frame_done_o, underflow_o, cfg_err_o;
    logic [15:0]   underflow_cnt_o;

    always #5 clk = ~clk;

    frame_sync_tx #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i),
        .h_total_i(h_total_i), .h_sync_len_i(h_sync_len_i),
        .h_act_start_i(h_act_start_i), .h_act_len_i(h_act_len_i),
        .v_total_i(v_total_i), .v_sync_len_i(v_sync_len_i),
        .v_act_start_i(v_act_start_i), .v_act_len_i(v_act_len_i),
        .sample_data_i(sample_data_i), .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o), .dac_data_o(dac_data_o),
        .dac_valid_o(dac_valid_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .frame_done_o(frame_done_o), .underflow_o(underflow_o),
        .underflow_cnt_o(underflow_cnt_o), .cfg_err_o(cfg_err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {int ht, hs, has, hal, vt, vs, vas, val;} cfg_t;

    function automatic cfg_t cur_inputs();
        cfg_t c;
        c.ht = int'(h_total_i);     c.hs = int'(h_sync_len_i);
        c.has = int'(h_act_start_i); c.hal = int'(h_act_len_i);
        c.vt = int'(v_total_i);     c.vs = int'(v_sync_len_i);
        c.vas = int'(v_act_start_i); c.val = int'(v_act_len_i);
        return c;
    endfunction

    function automatic bit cfg_ok(cfg_t c);
        return c.ht >= 2 && c.vt >= 1 && c.hs < c.ht && c.vs < c.vt && c.hal > 0 && c.val > 0
            && c.has + c.hal <= c.ht && c.vas + c.val <= c.vt;
    endfunction

    function automatic bit in_window(cfg_t c, int k);
        int h, v;
        h = k % c.ht;
        v = k / c.ht;
        return h >= c.has && h < c.has + c.hal && v >= c.vas && v < c.vas + c.val;
    endfunction

    task automatic set_cfg(input cfg_t c);
        h_total_i = CW'(c.ht);  h_sync_len_i = CW'(c.hs);
        h_act_start_i = CW'(c.has); h_act_len_i = CW'(c.hal);
        v_total_i = CW'(c.vt);  v_sync_len_i = CW'(c.vs);
        v_act_start_i = CW'(c.vas); v_act_len_i = CW'(c.val);
    endtask

    function automatic cfg_t base_cfg();
        cfg_t c;
        c.ht = 10; c.hs = 2; c.has = 3; c.hal = 4;
        c.vt = 5;  c.vs = 1; c.vas = 2; c.val = 2;
        return c;
    endfunction

    function automatic cfg_t rand_valid();
        cfg_t c;
        c.ht = $urandom_range(2, 12);  c.hs = $urandom_range(0, c.ht - 1);
        c.hal = $urandom_range(1, c.ht); c.has = $urandom_range(0, c.ht - c.hal);
        c.vt = $urandom_range(1, 5);   c.vs = $urandom_range(0, c.vt - 1);
        c.val = $urandom_range(1, c.vt); c.vas = $urandom_range(0, c.vt - c.val);
        return c;
    endfunction

    function automatic cfg_t rand_any();
        cfg_t c;
        c.ht = $urandom_range(0, 12);  c.hs = $urandom_range(0, 12);
        c.has = $urandom_range(0, 12); c.hal = $urandom_range(0, 12);
        c.vt = $urandom_range(0, 5);   c.vs = $urandom_range(0, 5);
        c.vas = $urandom_range(0, 5);  c.val = $urandom_range(0, 5);
        return c;
    endfunction

    // Reference model: frame position kept as a single index k; h/v derived by div/mod.
    cfg_t        m_cfg;
    bit          m_run, m_arm, m_drain, m_wait_low, m_err;
    int          m_k, m_ucnt;
    bit          e_hs, e_vs, e_dv, e_fd, e_uf;
    logic [DW-1:0] e_data = '0;

    function automatic bit m_ready();
        return m_run && in_window(m_cfg, m_k);
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_run = 0; m_arm = 0; m_drain = 0; m_wait_low = 0; m_err = 0;
            m_k = 0; m_ucnt = 0;
            e_hs = 0; e_vs = 0; e_dv = 0; e_fd = 0; e_uf = 0; e_data = '0;
        end else begin
            bit failed, act;
            failed = 0;
            e_hs = 0; e_vs = 0; e_dv = 0; e_fd = 0; e_uf = 0; e_data = '0;
            if (m_run) begin
                act    = in_window(m_cfg, m_k);
                e_hs   = (m_k % m_cfg.ht) < m_cfg.hs;
                e_vs   = (m_k / m_cfg.ht) < m_cfg.vs;
                e_dv   = act;
                e_data = (act && sample_valid_i) ? sample_data_i : '0;
                e_uf   = act && !sample_valid_i;
                if (e_uf && m_ucnt < 65535) m_ucnt++;
                e_fd   = (m_k == m_cfg.ht * m_cfg.vt - 1);
                m_k++;
                if (m_k == m_cfg.ht * m_cfg.vt) begin
                    m_k = 0;
                    if (enable_i) m_cfg = cur_inputs();
                    else begin m_run = 0; m_drain = 1; end
                end
            end else if (m_arm) begin
                m_arm  = 0;
                m_ucnt = 0;
                m_cfg  = cur_inputs();
                failed = !cfg_ok(m_cfg);
                m_err  = failed;
                if (failed) m_wait_low = 1;
                else begin m_run = 1; m_k = 0; end
            end else if (m_drain) begin
                m_drain = 0;
            end else if (enable_i && !m_wait_low) begin
                m_arm = 1;
            end
            if (!enable_i && !failed) m_wait_low = 0;
        end
    end

    // Per-cycle comparison of every output against the model, plus per-frame tallies.
    int hs_run = 0, vs_run = 0, dv_run = 0, uf_run = 0, frames = 0;
    int last_hs = 0, last_vs = 0, last_dv = 0, last_uf = 0;

    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            check_eq("out", {hsync_o, vsync_o, dac_valid_o, frame_done_o, underflow_o, cfg_err_o,
                             underflow_cnt_o, dac_data_o},
                            {e_hs, e_vs, e_dv, e_fd, e_uf, m_err, 16'(m_ucnt), e_data});
            check_eq("ready", sample_ready_o, m_ready());
            if (hsync_o) hs_run++;
            if (vsync_o) vs_run++;
            if (dac_valid_o) dv_run++;
            if (underflow_o) uf_run++;
            if (frame_done_o) begin
                frames++;
                last_hs = hs_run; last_vs = vs_run; last_dv = dv_run; last_uf = uf_run;
                $display("frame %0d done: hs=%0d vs=%0d dv=%0d uf=%0d ucnt=%0d",
                         frames, hs_run, vs_run, dv_run, uf_run, underflow_cnt_o);
                hs_run = 0; vs_run = 0; dv_run = 0; uf_run = 0;
            end
        end
    end

    // Upstream source: data is a sequence number that advances on each handshake.
    int drv_cyc = 0;
    int seq = 0;
    bit rdy_prev = 0;
    int vmode = 0;
    int act_seen = 0;

    task automatic step();
        bit v;
        @(negedge clk);
        drv_cyc++;
        if (sample_valid_i && rdy_prev) seq++;
        case (vmode)
            0: v = 1;
            1: v = ($urandom_range(0, 3) != 0);
            default: begin
                v = 1;
                if (m_ready()) begin
                    if (act_seen == 2) v = 0;
                    act_seen++;
                end
            end
        endcase
        sample_valid_i = v;
        sample_data_i  = v ? DW'(seq) : DW'($urandom);
        rdy_prev       = sample_ready_o;
    endtask

    task automatic wait_fd(input int budget, output int t);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (frame_done_o) found = 1;
        end
        check_eq("fd_wait", found, 1);
        t = drv_cyc;
    endtask

    task automatic wait_k(input int k, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (m_run && m_k == k) found = 1;
        end
        check_eq("k_wait", found, 1);
    endtask

    initial begin
        int t0, t1, t2, s0, hs_seen, lat;
        bit found;
        reset_n = 0; enable_i = 0; sample_valid_i = 0; sample_data_i = '0;
        set_cfg(base_cfg());
        repeat (3) step();
        check_eq("rst_state", {hsync_o, vsync_o, dac_valid_o, frame_done_o, underflow_o, cfg_err_o,
                               sample_ready_o, underflow_cnt_o, dac_data_o}, 0);
        reset_n = 1;

        // Base raster, always-valid incrementing source.
        $display("phase: base raster");
        seq = 0; vmode = 0; enable_i = 1;
        wait_fd(200, t0);
        check_eq("seq_f1", seq, 8);
        wait_fd(200, t1);
        check_eq("frame_len", t1 - t0, 50);
        check_eq("seq_f2", seq, 16);
        step();
        check_eq("hs_per_frame", last_hs, 10);
        check_eq("vs_per_frame", last_vs, 10);
        check_eq("dv_per_frame", last_dv, 8);

        // Single missing sample on the 3rd active slot.
        $display("phase: underflow");
        wait_k(0, 200);
        act_seen = 0; vmode = 2; s0 = seq;
        wait_fd(200, t0);
        step();
        check_eq("ucnt", underflow_cnt_o, 1);
        check_eq("uf_pulses", last_uf, 1);
        check_eq("accepted", seq - s0, 7);
        vmode = 0;

        // Rejected config, then re-arm after an enable toggle.
        $display("phase: config error");
        enable_i = 0;
        wait_fd(200, t0);
        repeat (3) step();
        h_act_start_i = 16'd8;
        enable_i = 1;
        repeat (5) step();
        check_eq("cfg_err_set", cfg_err_o, 1);
        hs_seen = 0;
        repeat (60) begin step(); if (hsync_o) hs_seen++; end
        check_eq("no_strobes", hs_seen, 0);
        h_act_start_i = 16'd3;
        repeat (10) step();
        check_eq("cfg_err_hold", cfg_err_o, 1);
        enable_i = 0; step();
        enable_i = 1; repeat (3) step();
        check_eq("cfg_err_clr", cfg_err_o, 0);
        wait_fd(200, t0);

        // Enable dropped mid-frame: frame completes, then outputs go quiet.
        $display("phase: enable drop");
        wait_k(17, 100);
        enable_i = 0;
        wait_fd(200, t1);
        check_eq("drop_len", t1 - t0, 50);
        repeat (5) begin
            step();
            check_eq("quiet", {hsync_o, vsync_o, dac_valid_o, frame_done_o, underflow_o, dac_data_o}, 0);
        end

        // h_total changed mid-frame applies at the next frame boundary.
        $display("phase: h_total change");
        enable_i = 1;
        wait_fd(200, t0);
        wait_k(20, 100);
        h_total_i = 16'd12;
        wait_fd(200, t1);
        wait_fd(200, t2);
        check_eq("len_before", t1 - t0, 50);
        check_eq("len_after", t2 - t1, 60);

        // Random configs, valid patterns and enable toggles.
        $display("phase: random");
        vmode = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                if (enable_i) enable_i = 0;
                else begin
                    if (!m_run && $urandom_range(0, 3) == 0) set_cfg(rand_any());
                    else set_cfg(rand_valid());
                    enable_i = 1;
                end
            end else if (m_run && $urandom_range(0, 19) == 0) begin
                set_cfg(rand_valid());
            end
            step();
        end

        // Reset in the active window, then restart with enable held high.
        $display("phase: reset mid-frame");
        vmode = 0; enable_i = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin step(); if (!m_run && !m_drain) found = 1; end
        check_eq("stop_wait", found, 1);
        repeat (3) step();
        set_cfg(base_cfg());
        enable_i = 1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin step(); if (m_ready()) found = 1; end
        check_eq("act_wait", found, 1);
        step();
        #2 reset_n = 0;
        #1 check_eq("rst_async", {hsync_o, vsync_o, dac_valid_o, frame_done_o, underflow_o, cfg_err_o,
                                  sample_ready_o, underflow_cnt_o, dac_data_o}, 0);
        repeat (2) step();
        reset_n = 1;
        lat = 0; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            lat++;
            if (hsync_o) found = 1;
        end
        check_eq("hs_latency", lat, 3);
        wait_fd(200, t0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
